dct4_fwd: RTL and testbench

Four-point forward DCT engine using the integer basis 64/83/36; the transform counterpart of the team's inverse-DCT datapath. Samples arrive serially over a valid/ready stream, are buffered, transformed with an even/odd butterfly, and leave as four serial coefficients over a second valid/ready stream. It sits upstream of quantisation, and its coefficient order matches the inverse-DCT input order (y0..y3 on d_in_1..d_in_4).

---
 rtl/dct4_fwd.sv | 174 +++++++++++++++++
 tb/tb_dct4_fwd.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dct4_fwd.sv
// ---------------------------------------------------------------------------
// dct4_fwd -- four-point forward DCT engine (integer basis 64/83/36)
//
// Collects four serial samples x0..x3, runs an even/odd butterfly in one
// cycle, then streams the coefficients y0..y3 out serially. Input and output
// never overlap: a block is fully drained before the next one is accepted.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous reset, ACTIVE LOW despite the name
//   s_data   in   signed input sample (IN_W), order x0,x1,x2,x3
//   s_valid  in   s_data valid
//   s_ready  out  block accepts a sample this cycle
//   m_data   out  signed coefficient (OUT_W)
//   m_idx    out  coefficient index 0..3 of m_data
//   m_last   out  high alongside y3
//   m_valid  out  m_data valid
//   m_ready  in   downstream accepts m_data
//
// Configuration macro:
//   DCT4_ROUND_EN  when defined, each coefficient becomes (y+64)>>>7
//                  (round-half-up), sign-extended to OUT_W.
// ---------------------------------------------------------------------------
module dct4_fwd #(
  parameter int IN_W  = 8,
  parameter int OUT_W = IN_W + 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic [1:0]              m_idx,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int EW = IN_W + 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [1:0]              oidx_q, oidx_d;
  logic                    ready_q;
  logic signed [IN_W-1:0]  x_q [4];
  logic signed [OUT_W-1:0] y_q [4];

  logic                    loadEn;
  logic                    calcEn;

  logic signed [EW-1:0]    e0, e1, o0, o1;
  logic signed [OUT_W-1:0] e0w, e1w, o0w, o1w;
  logic signed [OUT_W-1:0] y0c, y1c, y2c, y3c;

  // Constant multiplies built from shifts and adds only.
  function automatic logic signed [OUT_W-1:0] mul83(input logic signed [OUT_W-1:0] v);
    return (v <<< 6) + (v <<< 4) + (v <<< 1) + v;
  endfunction

  function automatic logic signed [OUT_W-1:0] mul36(input logic signed [OUT_W-1:0] v);
    return (v <<< 5) + (v <<< 2);
  endfunction

  // Final scaling applied as the coefficients are registered.
  function automatic logic signed [OUT_W-1:0] scaleOut(input logic signed [OUT_W-1:0] v);
`ifdef DCT4_ROUND_EN
    return (v + OUT_W'(64)) >>> 7;
`else
    return v;
`endif
  endfunction

  // Even/odd butterfly. Everything is widened to OUT_W before the constant
  // multiplies, which is wide enough that no intermediate can overflow.
  always_comb begin
    e0  = EW'(x_q[0]) + EW'(x_q[3]);
    e1  = EW'(x_q[1]) + EW'(x_q[2]);
    o0  = EW'(x_q[0]) - EW'(x_q[3]);
    o1  = EW'(x_q[1]) - EW'(x_q[2]);
    e0w = OUT_W'(e0);
    e1w = OUT_W'(e1);
    o0w = OUT_W'(o0);
    o1w = OUT_W'(o1);
    y0c = (e0w + e1w) <<< 6;
    y2c = (e0w - e1w) <<< 6;
    y1c = mul83(o0w) + mul36(o1w);
    y3c = mul36(o0w) - mul83(o1w);
  end

  // Next-state logic. ready_q gates LOAD so that no sample is taken in the
  // first cycle after reset is released.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oidx_d  = oidx_q;
    loadEn  = 1'b0;
    calcEn  = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_valid && ready_q) begin
          loadEn = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        calcEn  = 1'b1;
        oidx_d  = 2'd0;
        state_d = OUT;
      end
      OUT: begin
        if (m_ready) begin
          oidx_d = oidx_q + 2'd1;
          if (oidx_q == 2'd3) begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = 2'd0;
        oidx_d  = 2'd0;
      end
    endcase
  end

  // State, sample buffer and coefficient registers. s_ready is registered
  // from the next state, so it rises the cycle after the last output is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      oidx_q  <= 2'd0;
      ready_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oidx_q  <= oidx_d;
      ready_q <= (state_d == LOAD);
      if (loadEn) begin
        x_q[cnt_q] <= s_data;
      end
      if (calcEn) begin
        y_q[0] <= scaleOut(y0c);
        y_q[1] <= scaleOut(y1c);
        y_q[2] <= scaleOut(y2c);
        y_q[3] <= scaleOut(y3c);
      end
    end
  end

  // Output stream; data is forced to zero whenever nothing is offered.
  always_comb begin
    s_ready = ready_q;
    m_valid = (state_q == OUT);
    m_idx   = oidx_q;
    m_last  = (state_q == OUT) && (oidx_q == 2'd3);
    m_data  = (state_q == OUT) ? y_q[oidx_q] : '0;
  end

endmodule

// File: tb/tb_dct4_fwd.sv
// ---------------------------------------------------------------------------
// tb_dct4_fwd -- directed self-checking bench for dct4_fwd.
// Expected coefficients are hand-computed constants for each test block.
// ---------------------------------------------------------------------------
module tb_dct4_fwd;

  logic               clk;
  logic               reset;
  logic signed [7:0]  sData;
  logic               sValid;
  logic               sReady;
  logic signed [16:0] mData;
  logic [1:0]         mIdx;
  logic               mLast;
  logic               mValid;
  logic               mReady;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int lastAccept = 0;
  int firstAccept = 0;
  int startA = 0;
  int startB = 0;

`ifdef DCT4_ROUND_EN
  localparam logic signed [16:0] R0 = 50,    R1 = -22,  R2 = 0, R3 = -2;
  localparam logic signed [16:0] DP = 254,   DN = -256;
  localparam logic signed [16:0] A0 = -1,    A2 = 255;
`else
  localparam logic signed [16:0] R0 = 6400,  R1 = -2850, R2 = 0, R3 = -250;
  localparam logic signed [16:0] DP = 32512, DN = -32768;
  localparam logic signed [16:0] A0 = -128,  A2 = 32640;
`endif
  localparam logic signed [16:0] Z = 0;

  dct4_fwd dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (sData),
    .s_valid (sValid),
    .s_ready (sReady),
    .m_data  (mData),
    .m_idx   (mIdx),
    .m_last  (mLast),
    .m_valid (mValid),
    .m_ready (mReady)
  );

  // 10 ns clock and a free-running edge counter for timing checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Hard stop in case a sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one sample starting at a negedge; returns at the negedge after it
  // has been accepted.
  task automatic applyStimulus(input logic signed [7:0] v);
    int waits = 0;
    while (!sReady && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) checkOutput("sready_timeout", sReady, 1);
    sData  = v;
    sValid = 1'b1;
    @(negedge clk);
    lastAccept = cycle;
  endtask

  // Send a full block; gap idles s_valid between samples, keep leaves
  // s_valid high afterwards with junk data.
  task automatic sendBlock(input logic signed [7:0] a, b, c, d,
                           input int gap, input bit keep);
    logic signed [7:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(v[i]);
      if (i == 0) firstAccept = lastAccept;
      if (gap > 0 && i < 3) begin
        sValid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    if (keep) sData = 8'sd99;
    else sValid = 1'b0;
    checkOutput("calc_mvalid", mValid, 0);
    checkOutput("calc_sready", sReady, 0);
    @(negedge clk);
  endtask

  // Drain and check one output block, optionally stalling on index stallAt.
  task automatic checkBlock(input string tag, input logic signed [16:0] e0, e1, e2, e3,
                            input int stallAt);
    logic signed [16:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    for (int i = 0; i < 4; i++) begin
      if (i == stallAt) begin
        mReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput({tag, "_stall_data"}, mData, ex[i]);
          checkOutput({tag, "_stall_idx"}, mIdx, i);
          checkOutput({tag, "_stall_sready"}, sReady, 0);
        end
        mReady = 1'b1;
      end
      checkOutput({tag, "_mvalid"}, mValid, 1);
      checkOutput({tag, "_data"}, mData, ex[i]);
      checkOutput({tag, "_idx"}, mIdx, i);
      checkOutput({tag, "_last"}, mLast, (i == 3));
      @(negedge clk);
    end
    checkOutput({tag, "_done_mvalid"}, mValid, 0);
    checkOutput({tag, "_done_sready"}, sReady, 1);
  endtask

  initial begin
    reset  = 1'b0;
    sValid = 1'b0;
    sData  = '0;
    mReady = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_sready", sReady, 0);
    checkOutput("rst_mvalid", mValid, 0);
    checkOutput("rst_mdata", mData, 0);
    checkOutput("rst_midx", mIdx, 0);
    checkOutput("rst_mlast", mLast, 0);
    reset = 1'b1;
    checkOutput("rel_sready_low", sReady, 0);
    @(negedge clk);
    checkOutput("rel_sready_high", sReady, 1);

    // Ramp, with the CALC cycle checked inside sendBlock
    sendBlock(8'sd10, 8'sd20, 8'sd30, 8'sd40, 0, 1'b0);
    checkBlock("ramp", R0, R1, R2, R3, -1);

    // DC extremes and alternating pattern
    sendBlock(8'sd127, 8'sd127, 8'sd127, 8'sd127, 0, 1'b0);
    checkBlock("dcpos", DP, Z, Z, Z, -1);
    sendBlock(-8'sd128, -8'sd128, -8'sd128, -8'sd128, 0, 1'b0);
    checkBlock("dcneg", DN, Z, Z, Z, -1);
    sendBlock(8'sd127, -8'sd128, -8'sd128, 8'sd127, 0, 1'b0);
    checkBlock("alt", A0, Z, A2, Z, -1);

    // Backpressure on y1, then gapped input
    sendBlock(8'sd10, 8'sd20, 8'sd30, 8'sd40, 0, 1'b0);
    checkBlock("bp", R0, R1, R2, R3, 1);
    sendBlock(8'sd10, 8'sd20, 8'sd30, 8'sd40, 2, 1'b0);
    checkBlock("gap", R0, R1, R2, R3, -1);

    // Reset after two samples: partial block discarded
    applyStimulus(8'sd1);
    applyStimulus(8'sd2);
    sValid = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    checkOutput("midload_sready", sReady, 0);
    checkOutput("midload_mvalid", mValid, 0);
    reset = 1'b1;
    @(negedge clk);
    sendBlock(8'sd10, 8'sd20, 8'sd30, 8'sd40, 0, 1'b0);
    checkBlock("afterrst", R0, R1, R2, R3, -1);

    // Back-to-back blocks with s_valid held high
    sendBlock(8'sd10, 8'sd20, 8'sd30, 8'sd40, 0, 1'b1);
    startA = firstAccept;
    checkBlock("b2bA", R0, R1, R2, R3, -1);
    sendBlock(8'sd127, -8'sd128, -8'sd128, 8'sd127, 0, 1'b0);
    startB = firstAccept;
    checkBlock("b2bB", A0, Z, A2, Z, -1);
    checkOutput("b2b_period", startB - startA, 9);

    // Reset while a block is being offered
    sendBlock(8'sd10, 8'sd20, 8'sd30, 8'sd40, 0, 1'b0);
    mReady = 1'b0;
    checkOutput("outrst_pre_mvalid", mValid, 1);
    reset = 1'b0;
    #1;
    checkOutput("outrst_mvalid", mValid, 0);
    checkOutput("outrst_mdata", mData, 0);
    checkOutput("outrst_mlast", mLast, 0);
    @(negedge clk);
    reset = 1'b1;
    checkOutput("outrst_rel_sready", sReady, 0);
    @(negedge clk);
    checkOutput("outrst_sready", sReady, 1);
    mReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("outrst_no_pulse", mValid, 0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
